param_pipe_shift: RTL and testbench

- Parametrised elastic pipeline register chain: WIDTH-bit data moves through DEPTH clocked stages with valid/ready flow control.
- Generalises a fixed two-register nonblocking shift (a_in -> b_in) to arbitrary width and depth.
- Adds backpressure, bubble collapsing, occupancy count and synchronous flush.
- Sits between a producer and consumer as a race-free, stallable delay line.

---
 rtl/param_pipe_shift.sv | 130 +++++++++++++
 tb/tb_param_pipe_shift.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_pipe_shift.sv
// param_pipe_shift: parametrised elastic pipeline register chain.
//
// WIDTH-bit words move through DEPTH clocked stages under valid/ready flow
// control. A valid stage moves into an empty downstream stage even while the
// consumer stalls, which collapses bubbles. flush clears every stage valid
// without touching data. rst is synchronous and active high, and it overrides
// flush and all handshakes.
//
// Parameters:
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of stages (>= 2)
//
// Ports:
//   clk       clock; all state updates on posedge
//   rst       synchronous active-high reset
//   flush     synchronous clear of all stage valids
//   in_valid  producer presents in_data
//   in_data   producer data
//   in_ready  pipeline accepts in_data this cycle (combinational)
//   out_valid last stage holds a word for the consumer
//   out_data  data of the last stage
//   out_ready consumer accepts out_data this cycle
//   count     number of occupied stages
//
// Optional build macro PARAM_PIPE_TAP_EN adds the following ports:
//   tap_sel   stage to observe
//   tap_data  data of the selected stage
//   tap_valid valid of the selected stage
// tap_data and tap_valid are both combinational. If tap_sel is DEPTH or
// higher, tap_data and tap_valid are both 0.

module param_pipe_shift #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PARAM_PIPE_TAP_EN
  ,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           tap_data,
  output logic                       tap_valid
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [CntW-1:0]  count_q;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             accept;
  logic             drain;

  assign out_valid = vld_q[DEPTH-1] & ~flush;
  assign out_data  = dat_q[DEPTH-1];
  assign count     = count_q;

  // Advance decisions ripple from the output stage back to the input stage.
  // A slot is free next cycle if it is empty now or its word is moving on.
  always_comb begin
    adv  = '0;
    load = '0;
    drain = out_valid & out_ready;
    adv[DEPTH-1] = drain;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      adv[i-1] = vld_q[i-1] & (~vld_q[i] | adv[i]) & ~flush;
    end
    in_ready = (~vld_q[0] | adv[0]) & ~flush;
    accept   = in_valid & in_ready;
    load[0]  = accept;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else if (flush) begin
      // Data is left in place; only occupancy is discarded.
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      if (load[0]) begin
        vld_q[0] <= 1'b1;
        dat_q[0] <= in_data;
      end else if (adv[0]) begin
        vld_q[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          vld_q[i] <= 1'b1;
          dat_q[i] <= dat_q[i-1];
        end else if (adv[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
      count_q <= count_q + CntW'(accept) - CntW'(drain);
    end
  end

`ifdef PARAM_PIPE_TAP_EN
  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    if (32'(tap_sel) < DEPTH) begin
      tap_data  = dat_q[tap_sel];
      tap_valid = vld_q[tap_sel] & ~flush;
    end
  end
`else
  // Default build: no tap mux.
`endif

endmodule

// File: tb/tb_param_pipe_shift.sv
// Directed self-checking bench for param_pipe_shift (WIDTH=4, DEPTH=4).
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, once the combinational logic has settled.

module tb_param_pipe_shift;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       count;
`ifdef PARAM_PIPE_TAP_EN
  logic [1:0]       tap_sel = 2'd0;
  logic [WIDTH-1:0] tap_data;
  logic             tap_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  param_pipe_shift #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
`ifdef PARAM_PIPE_TAP_EN
    ,
    .tap_sel   (tap_sel),
    .tap_data  (tap_data),
    .tap_valid (tap_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bp_exp [5];
    bp_exp[0] = 4'hA; bp_exp[1] = 4'hB; bp_exp[2] = 4'hC;
    bp_exp[3] = 4'hD; bp_exp[4] = 4'hE;

    // Reset asserted for 2 cycles while the producer offers a word.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_count", 32'(count), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Latency: one word accepted at edge 0 reaches the output after edge 3.
    in_valid = 1'b1; in_data = 4'h9;
    tick();
    in_valid = 1'b0;
    check("lat_count_e0", 32'(count), 1);
    check("lat_ov_e0", 32'(out_valid), 0);
    tick();
    tick();
    check("lat_ov_e2", 32'(out_valid), 0);
    tick();
    check("lat_ov_e3", 32'(out_valid), 1);
    check("lat_od_e3", 32'(out_data), 4'h9);
    check("lat_count_e3", 32'(count), 1);
    tick();
    check("lat_count_e4", 32'(count), 0);
    check("lat_ov_e4", 32'(out_valid), 0);

    // Streaming: push 1..6 back to back; output appears after edges 3..8.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 6);
      in_data  = 4'(c + 1);
      #1;
      check("str_in_ready", 32'(in_ready), 1);
      tick();
      check("str_out_valid", 32'(out_valid), (c >= 3 && c <= 8) ? 1 : 0);
      if (c >= 3 && c <= 8) check("str_out_data", 32'(out_data), 32'(c - 2));
    end
    in_valid = 1'b0;
    check("str_count_end", 32'(count), 0);

    // Backpressure: fill the pipe with A..D while the consumer stalls.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(10 + k);
      tick();
    end
    check("bp_count_full", 32'(count), 4);
    in_data = 4'hE;
    #1;
    check("bp_in_ready_full", 32'(in_ready), 0);
    check("bp_out_data_head", 32'(out_data), 4'hA);
    tick();
    check("bp_count_hold", 32'(count), 4);
    check("bp_out_data_hold", 32'(out_data), 4'hA);
    // Drain A..E in order; E is accepted alongside the drain of A.
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_drain", 32'(in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_seq_valid", 32'(out_valid), 1);
      check("bp_seq_data", 32'(out_data), 32'(bp_exp[k]));
      tick();
      if (k == 0) begin
        check("bp_count_swap", 32'(count), 4);
        in_valid = 1'b0;
      end
    end
    check("bp_count_empty", 32'(count), 0);
    check("bp_ov_empty", 32'(out_valid), 0);

    // Bubble collapse under out_ready=0.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 4'h2;
    tick();
    in_valid = 1'b0;
    check("bub_head_valid", 32'(out_valid), 1);
    check("bub_head_data", 32'(out_data), 4'h1);
    tick();
    tick();
    tick();
    check("bub_count", 32'(count), 2);
    check("bub_head_stable", 32'(out_data), 4'h1);
    #1;
    check("bub_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    check("bub_second", 32'(out_data), 4'h2);
    check("bub_second_valid", 32'(out_valid), 1);
    tick();
    check("bub_drained", 32'(count), 0);

    // Flush a pipe holding three words, one of them at the output.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(7 + k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("fl_pre_count", 32'(count), 3);
    check("fl_pre_valid", 32'(out_valid), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 0);
    check("fl_out_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 32'(count), 0);
    for (int k = 0; k < 5; k++) begin
      check("fl_no_ghost", 32'(out_valid), 0);
      tick();
    end
    // Fresh word after flush has normal latency.
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_after_ov_e2", 32'(out_valid), 0);
    tick();
    check("fl_after_ov_e3", 32'(out_valid), 1);
    check("fl_after_od_e3", 32'(out_data), 4'h5);
    tick();

    // Reset mid-operation discards in-flight words.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rmid_count", 32'(count), 0);
    check("rmid_out_data", 32'(out_data), 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    check("rmid_count_one", 32'(count), 1);
    tick();
    tick();
    tick();
    check("rmid_od", 32'(out_data), 4'h6);
    check("rmid_ov", 32'(out_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
